// File: rtl/packet_mem_read_responder.sv
// Sized big-endian packet-buffer load over a 32-bit BRAM: 2-cycle response, 3 when the access straddles two words;
// busy stalls the requester, which must not strobe while busy. PKT_RD_BOUNDS_CHECK_EN adds the pkt_len bounds check.
module packet_mem_read_responder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  packet_mem_rd_en,
  input  logic [1:0]            transfer_sz,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [ADDR_WIDTH:0]   pkt_len,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  input  logic [31:0]           mem_rd_data,
  output logic [31:0]           resp_data,
  output logic                  resp_valid,
  output logic                  rd_err,
  output logic                  busy
);

  localparam int WAW = ADDR_WIDTH - 2;
  localparam logic [WAW-1:0] WORD_ONE = 1;

  typedef enum logic [1:0] {IDLE, WAIT1, WAIT2} state_t;

  state_t         state_q, state_d;
  logic [WAW-1:0] word_q, word_d, last_q, last_d;
  logic [1:0]     off_q, off_d;
  logic [1:0]     sz_q, sz_d;            // 0 word, 1 half, 2 byte
  logic           cross_q, cross_d;
  logic           err_q, err_d;
  logic [31:0]    held_q, held_d;
  logic [31:0]    resp_data_q, resp_data_d;
  logic           resp_valid_q, resp_valid_d;
  logic           rd_err_q, rd_err_d;
  logic           rd_en_c;

  logic [1:0]     req_sz;
  logic [2:0]     req_n;
  logic           req_cross;
  logic           req_oob;
  logic [63:0]    sel_src;
  logic [63:0]    sel_shift;
  logic [31:0]    sel_data;

  assign req_sz = (transfer_sz == 2'b11) ? 2'b10 : transfer_sz;

  always_comb begin
    req_n     = 3'd1;
    req_cross = 1'b0;
    case (req_sz)
      2'b00: begin
        req_n     = 3'd4;
        req_cross = (rd_addr[1:0] != 2'b00);
      end
      2'b01: begin
        req_n     = 3'd2;
        req_cross = (rd_addr[1:0] == 2'b11);
      end
      default: begin
        req_n     = 3'd1;
        req_cross = 1'b0;
      end
    endcase
  end

`ifdef PKT_RD_BOUNDS_CHECK_EN
  logic [ADDR_WIDTH:0] end_addr;
  assign end_addr = {1'b0, rd_addr} + {{(ADDR_WIDTH-2){1'b0}}, req_n};
  assign req_oob  = (end_addr > pkt_len);
`else
  logic unused_pkt_len;
  assign unused_pkt_len = ^pkt_len;
  assign req_oob        = 1'b0;
`endif

  // Non-crossing data sits in the upper half so one shift-and-truncate serves both cases.
  assign sel_src   = (state_q == WAIT2) ? {held_q, mem_rd_data} : {mem_rd_data, 32'h0};
  assign sel_shift = sel_src << {off_q, 3'b000};

  always_comb begin
    case (sz_q)
      2'b00:   sel_data = sel_shift[63:32];
      2'b01:   sel_data = {16'h0, sel_shift[63:48]};
      default: sel_data = {24'h0, sel_shift[63:56]};
    endcase
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    last_d       = last_q;
    off_d        = off_q;
    sz_d         = sz_q;
    cross_d      = cross_q;
    err_d        = err_q;
    held_d       = held_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = 1'b0;
    rd_err_d     = rd_err_q;
    rd_en_c      = 1'b0;
    mem_addr     = last_q;

    case (state_q)
      IDLE: begin
        if (packet_mem_rd_en) begin
          state_d = WAIT1;
          word_d  = rd_addr[ADDR_WIDTH-1:2];
          off_d   = rd_addr[1:0];
          sz_d    = req_sz;
          cross_d = req_cross && !req_oob;
          err_d   = req_oob;
          if (!req_oob) begin
            rd_en_c  = 1'b1;
            mem_addr = rd_addr[ADDR_WIDTH-1:2];
            last_d   = rd_addr[ADDR_WIDTH-1:2];
          end
        end
      end
      WAIT1: begin
        if (err_q) begin
          state_d      = IDLE;
          resp_data_d  = 32'h0;
          rd_err_d     = 1'b1;
          resp_valid_d = 1'b1;
        end else if (cross_q) begin
          state_d  = WAIT2;
          held_d   = mem_rd_data;
          rd_en_c  = 1'b1;
          mem_addr = word_q + WORD_ONE;
          last_d   = word_q + WORD_ONE;
        end else begin
          state_d      = IDLE;
          resp_data_d  = sel_data;
          rd_err_d     = 1'b0;
          resp_valid_d = 1'b1;
        end
      end
      WAIT2: begin
        state_d      = IDLE;
        resp_data_d  = sel_data;
        rd_err_d     = 1'b0;
        resp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      word_q       <= '0;
      last_q       <= '0;
      off_q        <= 2'b00;
      sz_q         <= 2'b00;
      cross_q      <= 1'b0;
      err_q        <= 1'b0;
      held_q       <= 32'h0;
      resp_data_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      last_q       <= last_d;
      off_q        <= off_d;
      sz_q         <= sz_d;
      cross_q      <= cross_d;
      err_q        <= err_d;
      held_q       <= held_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      rd_err_q     <= rd_err_d;
    end
  end

  // Gate with reset so an in-flight read enable vanishes the moment reset asserts.
  assign mem_rd_en  = rd_en_c & rst;
  assign resp_data  = resp_data_q;
  assign resp_valid = resp_valid_q;
  assign rd_err     = rd_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_packet_mem_read_responder.sv
// Directed bench for packet_mem_read_responder with a 1-cycle BRAM model; honours PKT_RD_BOUNDS_CHECK_EN.
module tb_packet_mem_read_responder;

  logic        clk;
  logic        rst;
  logic        packet_mem_rd_en;
  logic [1:0]  transfer_sz;
  logic [9:0]  rd_addr;
  logic [10:0] pkt_len;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rd_data;
  logic [31:0] resp_data;
  logic        resp_valid;
  logic        rd_err;
  logic        busy;

  logic [31:0] mem [0:255];
  int          rd_cnt;
  int          checks;
  int          passes;

  packet_mem_read_responder #(.ADDR_WIDTH(10)) dut (
    .clk              (clk),
    .rst              (rst),
    .packet_mem_rd_en (packet_mem_rd_en),
    .transfer_sz      (transfer_sz),
    .rd_addr          (rd_addr),
    .pkt_len          (pkt_len),
    .mem_rd_en        (mem_rd_en),
    .mem_addr         (mem_addr),
    .mem_rd_data      (mem_rd_data),
    .resp_data        (resp_data),
    .resp_valid       (resp_valid),
    .rd_err           (rd_err),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_addr];
      rd_cnt      <= rd_cnt + 1;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [1:0] sz, input logic [9:0] addr);
    packet_mem_rd_en = 1'b1;
    transfer_sz      = sz;
    rd_addr          = addr;
    #1;
  endtask

  task automatic test_reset();
    packet_mem_rd_en = 1'b1;
    next_cycle();
    next_cycle();
    checks++; if (resp_data !== 32'h0) $display("FAIL reset_resp_data got %h exp 00000000", resp_data); else passes++;
    checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b exp 0", resp_valid); else passes++;
    checks++; if (rd_err !== 1'b0) $display("FAIL reset_rd_err got %b exp 0", rd_err); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passes++;
    checks++; if (mem_rd_en !== 1'b0) $display("FAIL reset_mem_rd_en got %b exp 0", mem_rd_en); else passes++;
    packet_mem_rd_en = 1'b0;
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_byte();
    int c0;
    c0 = rd_cnt;
    request(2'b10, 10'd2);
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 8'd0) $display("FAIL byte_issue got en=%b addr=%0d exp en=1 addr=0", mem_rd_en, mem_addr); else passes++;
    next_cycle();
    packet_mem_rd_en = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || resp_valid !== 1'b0) $display("FAIL byte_t1 got busy=%b valid=%b exp busy=1 valid=0", busy, resp_valid); else passes++;
    next_cycle();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h00000033) $display("FAIL byte_resp got valid=%b data=%h exp valid=1 data=00000033", resp_valid, resp_data); else passes++;
    checks++; if (rd_err !== 1'b0 || busy !== 1'b0) $display("FAIL byte_flags got err=%b busy=%b exp err=0 busy=0", rd_err, busy); else passes++;
    checks++; if (rd_cnt - c0 !== 1) $display("FAIL byte_rd_count got %0d exp 1", rd_cnt - c0); else passes++;
    next_cycle();
    checks++; if (resp_valid !== 1'b0 || resp_data !== 32'h00000033) $display("FAIL byte_hold got valid=%b data=%h exp valid=0 data=00000033", resp_valid, resp_data); else passes++;
  endtask

  task automatic test_half_cross();
    int c0;
    c0 = rd_cnt;
    request(2'b01, 10'd3);
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 8'd0) $display("FAIL half_issue1 got en=%b addr=%0d exp en=1 addr=0", mem_rd_en, mem_addr); else passes++;
    next_cycle();
    // Strobe while busy must be ignored.
    request(2'b10, 10'h020);
    checks++; if (busy !== 1'b1 || mem_rd_en !== 1'b1 || mem_addr !== 8'd1) $display("FAIL half_issue2 got busy=%b en=%b addr=%0d exp busy=1 en=1 addr=1", busy, mem_rd_en, mem_addr); else passes++;
    next_cycle();
    packet_mem_rd_en = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || resp_valid !== 1'b0 || mem_rd_en !== 1'b0 || mem_addr !== 8'd1) $display("FAIL half_t2 got busy=%b valid=%b en=%b addr=%0d exp 1 0 0 1", busy, resp_valid, mem_rd_en, mem_addr); else passes++;
    next_cycle();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h00004455 || busy !== 1'b0) $display("FAIL half_resp got valid=%b data=%h busy=%b exp 1 00004455 0", resp_valid, resp_data, busy); else passes++;
    checks++; if (rd_cnt - c0 !== 2) $display("FAIL half_rd_count got %0d exp 2", rd_cnt - c0); else passes++;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    request(2'b00, 10'd4);
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 8'd1) $display("FAIL b2b_issue got en=%b addr=%0d exp en=1 addr=1", mem_rd_en, mem_addr); else passes++;
    next_cycle();
    packet_mem_rd_en = 1'b0;
    next_cycle();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h55667788) $display("FAIL b2b_resp1 got valid=%b data=%h exp 1 55667788", resp_valid, resp_data); else passes++;
    // Size 11 behaves as a byte access.
    request(2'b11, 10'd5);
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 8'd1) $display("FAIL b2b_accept got en=%b addr=%0d exp en=1 addr=1", mem_rd_en, mem_addr); else passes++;
    next_cycle();
    packet_mem_rd_en = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b1) $display("FAIL b2b_t3 got valid=%b busy=%b exp 0 1", resp_valid, busy); else passes++;
    next_cycle();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h00000066) $display("FAIL b2b_resp2 got valid=%b data=%h exp 1 00000066", resp_valid, resp_data); else passes++;
    next_cycle();
  endtask

  task automatic test_wrap();
    request(2'b00, 10'h3FE);
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 8'd255) $display("FAIL wrap_issue1 got en=%b addr=%0d exp en=1 addr=255", mem_rd_en, mem_addr); else passes++;
    next_cycle();
    packet_mem_rd_en = 1'b0;
    #1;
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 8'd0) $display("FAIL wrap_issue2 got en=%b addr=%0d exp en=1 addr=0", mem_rd_en, mem_addr); else passes++;
    next_cycle();
    next_cycle();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hCCDD1122) $display("FAIL wrap_resp got valid=%b data=%h exp 1 ccdd1122", resp_valid, resp_data); else passes++;
    next_cycle();
  endtask

  task automatic test_reset_abort();
    request(2'b00, 10'd1);
    next_cycle();
    packet_mem_rd_en = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || mem_rd_en !== 1'b0) $display("FAIL abort_async got busy=%b en=%b exp 0 0", busy, mem_rd_en); else passes++;
    checks++; if (resp_data !== 32'h0) $display("FAIL abort_data got %h exp 00000000", resp_data); else passes++;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL abort_no_resp got valid=%b busy=%b exp 0 0", resp_valid, busy); else passes++;
    request(2'b10, 10'd0);
    next_cycle();
    packet_mem_rd_en = 1'b0;
    next_cycle();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h00000011) $display("FAIL abort_recover got valid=%b data=%h exp 1 00000011", resp_valid, resp_data); else passes++;
    next_cycle();
  endtask

  task automatic test_bounds();
    int c0;
    c0 = rd_cnt;
    pkt_len = 11'd6;
    request(2'b00, 10'd4);
`ifdef PKT_RD_BOUNDS_CHECK_EN
    checks++; if (mem_rd_en !== 1'b0) $display("FAIL oob_no_read got en=%b exp 0", mem_rd_en); else passes++;
    next_cycle();
    packet_mem_rd_en = 1'b0;
    next_cycle();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h0 || rd_err !== 1'b1) $display("FAIL oob_resp got valid=%b data=%h err=%b exp 1 00000000 1", resp_valid, resp_data, rd_err); else passes++;
    checks++; if (rd_cnt - c0 !== 0) $display("FAIL oob_rd_count got %0d exp 0", rd_cnt - c0); else passes++;
`else
    checks++; if (mem_rd_en !== 1'b1) $display("FAIL nochk_read got en=%b exp 1", mem_rd_en); else passes++;
    next_cycle();
    packet_mem_rd_en = 1'b0;
    next_cycle();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h55667788 || rd_err !== 1'b0) $display("FAIL nochk_resp got valid=%b data=%h err=%b exp 1 55667788 0", resp_valid, resp_data, rd_err); else passes++;
    checks++; if (rd_cnt - c0 !== 1) $display("FAIL nochk_rd_count got %0d exp 1", rd_cnt - c0); else passes++;
`endif
    pkt_len = 11'h7FF;
    next_cycle();
  endtask

  initial begin
    checks           = 0;
    passes           = 0;
    rd_cnt           = 0;
    rst              = 1'b0;
    packet_mem_rd_en = 1'b0;
    transfer_sz      = 2'b00;
    rd_addr          = '0;
    pkt_len          = 11'h7FF;
    mem_rd_data      = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD0000 | i;
    mem[0]   = 32'h11223344;
    mem[1]   = 32'h55667788;
    mem[255] = 32'hAABBCCDD;

    test_reset();
    test_byte();
    test_half_cross();
    test_back_to_back();
    test_wrap();
    test_reset_abort();
    test_bounds();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/packet_mem_read_responder.md
# packet_mem_read_responder

Serves the packet-memory loads requested by the pipelined controller's stage-2 outputs (`packet_mem_rd_en`, `transfer_sz`). It converts a byte-addressed, sized big-endian load into one or two reads of the 32-bit packet buffer BRAM. It assembles and zero-extends the result and returns it to the datapath with a one-cycle valid pulse. It asserts `busy` so the controller can stall stages 0/1 while an unaligned access needs a second memory read.

## Interface
- `ADDR_WIDTH`, 10, packet buffer byte-address width; BRAM word address is `ADDR_WIDTH-2` bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `packet_mem_rd_en`  in  1  load request strobe from the stage-2 controller; sampled only in IDLE.
- `transfer_sz`  in  2  access size: 00 word (4 B), 01 half (2 B), 10 byte; 11 is treated as byte.
- `rd_addr`  in  `ADDR_WIDTH`  byte address of the first (most significant) byte.
- `pkt_len`  in  `ADDR_WIDTH+1`  packet length in bytes; used only with the bounds check.
- `mem_rd_en`  out  1  BRAM read enable (combinational).
- `mem_addr`  out  `ADDR_WIDTH-2`  BRAM word address (combinational).
- `mem_rd_data`  in  32  BRAM data; fixed 1-cycle latency; byte 0 of the word is in [31:24].
- `resp_data`  out  32  zero-extended load result (registered).
- `resp_valid`  out  1  one-cycle pulse; `resp_data` is valid in the same cycle.
- `rd_err`  out  1  out-of-bounds flag, qualified by `resp_valid`.
- `busy`  out  1  high while the FSM is not IDLE (registered state decode).

## Operation
- States: IDLE, WAIT1, WAIT2.
- **Request in IDLE (cycle T):**
  - `mem_rd_en`=1, `mem_addr`=`rd_addr[ADDR_WIDTH-1:2]`.
  - Latch the offset `o`=`rd_addr[1:0]`, the size `n` (4/2/1), and a cross flag = (`o`+`n` > 4).
  - Next state is WAIT1.
- **WAIT1, no cross:**
  - Register `resp_data` = bytes `o`..`o+n-1` of `mem_rd_data`, zero-extended.
  - Set `resp_valid`=1 and return to IDLE.
- **WAIT1, cross:**
  - Hold `mem_rd_data` in a 32-bit register.
  - Issue the second read: `mem_rd_en`=1, `mem_addr` = first word address + 1, modulo 2^(`ADDR_WIDTH-2`) (wraps to 0).
  - Next state is WAIT2.
- **WAIT2:**
  - Form the 64-bit value {held word, `mem_rd_data`} and select bytes `o`..`o+n-1`, zero-extended.
  - Register `resp_data`, set `resp_valid`=1, return to IDLE.
- Byte reads never cross; half reads cross only when `o`=3; word reads cross whenever `o`≠0.
- `packet_mem_rd_en` while `busy` is a protocol violation: it is ignored, with no read issued and no state change.
- Outside a request, `mem_rd_en`=0 and `mem_addr` holds its last value.

## Timing
- Reset values: state IDLE, `resp_data`=0, `resp_valid`=0, `rd_err`=0, `busy`=0, held word 0.
- Reset asserted mid-operation aborts the access:
  - No `resp_valid` pulse follows.
  - `mem_rd_en` drops immediately (asynchronous).
  - The next request after reset is released is served normally.
- Non-crossing latency: request at T, `busy`=1 at T+1, `resp_valid` at T+2 with `busy`=0.
- Crossing latency: `busy`=1 at T+1 and T+2, `resp_valid` at T+3.
- Back-to-back: a new request is accepted in the same cycle that `resp_valid` pulses.
- `resp_data` holds its value until the next response; `resp_valid` is never high for two consecutive cycles.

## Configuration
- **`PKT_RD_BOUNDS_CHECK_EN` defined:**
  - At request acceptance, if `rd_addr`+`n` > `pkt_len` (computed at `ADDR_WIDTH+1` bits), the access is out of bounds.
  - No `mem_rd_en` is issued; the FSM goes IDLE→WAIT1→IDLE.
  - `resp_valid` pulses at T+2 with `resp_data`=0 and `rd_err`=1.
- **Not defined:** `pkt_len` is ignored, `rd_err` is constant 0, and the wrap-around rule applies to every access.

## Test plan
1. BRAM word0=0x11223344; byte read at addr 2 -> `resp_data`=0x00000033 at T+2, `rd_err`=0, one `mem_rd_en` pulse at address 0.
2. Words 0/1 = 0x11223344/0x55667788; half read at addr 3 -> reads at word addresses 0 then 1, `busy` high for 2 cycles, `resp_data`=0x00004455 at T+3.
3. Aligned word read at addr 4 -> `resp_data`=0x55667788 at T+2; a second request at T+2 is accepted and answered at T+4.
4. `ADDR_WIDTH`=10, word255=0xAABBCCDD, word0=0x11223344; word read at addr 0x3FE -> second read at word address 0, `resp_data`=0xCCDD1122.
5. Crossing word read at addr 1, `rst` pulled low at T+1 -> `busy`=0, `resp_valid` stays 0, `resp_data`=0; after release, a byte read at addr 0 returns 0x00000011.
6. With the macro defined, `pkt_len`=6 and a word read at addr 4 -> no `mem_rd_en`, `resp_valid` at T+2 with `resp_data`=0 and `rd_err`=1. Without the macro, the same read returns 0x55667788 with `rd_err`=0.
